// File: rtl/pipe_reg_nop_flush_if.sv
// Bundle between an upstream stage and a pipe_reg_nop_flush stage register.
// Upstream drives the master side; the register presents the slave side.
interface pipe_reg_nop_flush_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PC_W  = 16,
  parameter int unsigned CNT_W = 8
);
  logic             stall;
  logic             flush;
  logic             valid_in;
  logic [WIDTH-1:0] instr_in;
  logic [PC_W-1:0]  pc_in;
  logic [WIDTH-1:0] instr_out;
  logic [PC_W-1:0]  pc_out;
  logic             valid_out;
  logic             flushing;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output stall, flush, valid_in, instr_in, pc_in,
    input  instr_out, pc_out, valid_out, flushing, bubble_cnt
  );

  modport slave (
    input  stall, flush, valid_in, instr_in, pc_in,
    output instr_out, pc_out, valid_out, flushing, bubble_cnt
  );
endinterface

// File: rtl/pipe_reg_nop_flush.sv
// Pipeline stage register with stall, multi-cycle NOP flush bursts and a
// saturating count of inserted bubbles.
module pipe_reg_nop_flush #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      PC_W      = 16,
  parameter logic [WIDTH-1:0] NOP_VAL   = WIDTH'(16'h0800),
  parameter int unsigned      FLUSH_LEN = 1,
  parameter int unsigned      CNT_W     = 8
) (
  input logic                clk,
  input logic                rst,
  pipe_reg_nop_flush_if.slave bus
);

  localparam int unsigned     FlW    = $clog2(FLUSH_LEN + 1);
  localparam logic [FlW-1:0]  FlLast = FlW'(FLUSH_LEN - 1);

  typedef enum logic {StRun, StFlush} state_e;

  state_e           state_q;
  logic [FlW-1:0]   fl_cnt_q;
  logic [WIDTH-1:0] instr_q;
  logic [PC_W-1:0]  pc_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      fl_cnt_q <= '0;
      instr_q  <= NOP_VAL;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (bus.flush) begin
      // A flush restarts the burst from full length; pc is left as-is.
      instr_q  <= NOP_VAL;
      valid_q  <= 1'b0;
      fl_cnt_q <= FlLast;
      state_q  <= (FLUSH_LEN > 1) ? StFlush : StRun;
      cnt_q    <= cnt_inc;
    end else if (state_q == StFlush) begin
      // Bubbles keep coming regardless of stall until the burst is spent.
      instr_q  <= NOP_VAL;
      valid_q  <= 1'b0;
      fl_cnt_q <= fl_cnt_q - FlW'(1);
      if (fl_cnt_q == FlW'(1)) state_q <= StRun;
      cnt_q    <= cnt_inc;
    end else if (!bus.stall) begin
      pc_q <= bus.pc_in;
      if (bus.valid_in) begin
        instr_q <= bus.instr_in;
        valid_q <= 1'b1;
      end else begin
        instr_q <= NOP_VAL;
        valid_q <= 1'b0;
        cnt_q   <= cnt_inc;
      end
    end
  end

  assign bus.instr_out  = instr_q;
  assign bus.pc_out     = pc_q;
  assign bus.valid_out  = valid_q;
  assign bus.flushing   = (state_q == StFlush);
  assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_reg_nop_flush.sv
// Directed bench: a vector table on a FLUSH_LEN=3 instance, plus hand-written
// sequences on a FLUSH_LEN=1, CNT_W=2 instance for saturation and single bubbles.
module tb_pipe_reg_nop_flush;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  pipe_reg_nop_flush_if #(.WIDTH(16), .PC_W(16), .CNT_W(8)) bus_a ();
  pipe_reg_nop_flush_if #(.WIDTH(16), .PC_W(16), .CNT_W(2)) bus_b ();

  pipe_reg_nop_flush #(
    .WIDTH(16), .PC_W(16), .NOP_VAL(16'h0800), .FLUSH_LEN(3), .CNT_W(8)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(bus_a)
  );

  pipe_reg_nop_flush #(
    .WIDTH(16), .PC_W(16), .NOP_VAL(16'h0800), .FLUSH_LEN(1), .CNT_W(2)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(bus_b)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic [15:0] instr_in;
    logic [15:0] pc_in;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
    logic        exp_valid;
    logic        exp_flushing;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    else n_pass++;
  endtask

  task automatic drive_b(input logic r, input logic s, input logic f, input logic v,
                         input logic [15:0] ins, input logic [15:0] pc);
    @(negedge clk);
    rst_b          = r;
    bus_b.stall    = s;
    bus_b.flush    = f;
    bus_b.valid_in = v;
    bus_b.instr_in = ins;
    bus_b.pc_in    = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] sat_exp[5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    //        rst  stl  fl   vin  instr     pc        e_instr   e_pc      e_v  e_fl e_cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hdead, 16'hbeef, 16'h0800, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0010, 16'h1234, 16'h0010, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h5555, 16'h0020, 16'h1234, 16'h0010, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h6666, 16'h0030, 16'h1234, 16'h0010, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h7777, 16'h0040, 16'h1234, 16'h0010, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h8888, 16'h0050, 16'h0800, 16'h0010, 1'b0, 1'b1, 8'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h9999, 16'h0060, 16'h0800, 16'h0010, 1'b0, 1'b1, 8'd2};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h9999, 16'h0060, 16'h0800, 16'h0010, 1'b0, 1'b0, 8'd3};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'habcd, 16'h0070, 16'habcd, 16'h0070, 1'b1, 1'b0, 8'd3};
    // Restart on the second bubble with stall held: four bubbles, then hold.
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h1111, 16'h0080, 16'h0800, 16'h0070, 1'b0, 1'b1, 8'd4};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h1111, 16'h0080, 16'h0800, 16'h0070, 1'b0, 1'b1, 8'd5};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1111, 16'h0080, 16'h0800, 16'h0070, 1'b0, 1'b1, 8'd6};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1111, 16'h0080, 16'h0800, 16'h0070, 1'b0, 1'b0, 8'd7};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1111, 16'h0080, 16'h0800, 16'h0070, 1'b0, 1'b0, 8'd7};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h2222, 16'h0090, 16'h2222, 16'h0090, 1'b1, 1'b0, 8'd7};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h3333, 16'h00a0, 16'h0800, 16'h00a0, 1'b0, 1'b0, 8'd8};
    // Mid-burst reset, then an immediate real load.
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h3333, 16'h00a0, 16'h0800, 16'h00a0, 1'b0, 1'b1, 8'd9};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h3333, 16'h00a0, 16'h0800, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4444, 16'h00b0, 16'h4444, 16'h00b0, 1'b1, 1'b0, 8'd0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.stall = 1'b0; bus_a.flush = 1'b0; bus_a.valid_in = 1'b0;
    bus_a.instr_in = '0; bus_a.pc_in = '0;
    bus_b.stall = 1'b0; bus_b.flush = 1'b0; bus_b.valid_in = 1'b0;
    bus_b.instr_in = '0; bus_b.pc_in = '0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst_a          = vecs[i].rst;
      bus_a.stall    = vecs[i].stall;
      bus_a.flush    = vecs[i].flush;
      bus_a.valid_in = vecs[i].valid_in;
      bus_a.instr_in = vecs[i].instr_in;
      bus_a.pc_in    = vecs[i].pc_in;
      @(posedge clk);
      #1;
      check("a_instr", i, 32'(bus_a.instr_out), 32'(vecs[i].exp_instr));
      check("a_pc", i, 32'(bus_a.pc_out), 32'(vecs[i].exp_pc));
      check("a_valid", i, 32'(bus_a.valid_out), 32'(vecs[i].exp_valid));
      check("a_flushing", i, 32'(bus_a.flushing), 32'(vecs[i].exp_flushing));
      check("a_cnt", i, 32'(bus_a.bubble_cnt), 32'(vecs[i].exp_cnt));
    end

    // Saturation on the 2-bit counter: five idle loads.
    drive_b(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_b(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("b_rst_cnt", 0, 32'(bus_b.bubble_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive_b(1'b0, 1'b0, 1'b0, 1'b0, 16'h5a5a, 16'(16'h0100 + i));
      check("b_sat_cnt", i, 32'(bus_b.bubble_cnt), 32'(sat_exp[i]));
      check("b_sat_valid", i, 32'(bus_b.valid_out), 32'd0);
      check("b_sat_instr", i, 32'(bus_b.instr_out), 32'h0800);
      check("b_sat_pc", i, 32'(bus_b.pc_out), 32'(16'h0100 + i));
    end

    // Single-bubble flush never enters the burst state.
    drive_b(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_b(1'b0, 1'b0, 1'b0, 1'b1, 16'hc0de, 16'h0200);
    check("b_load_instr", 0, 32'(bus_b.instr_out), 32'hc0de);
    drive_b(1'b0, 1'b0, 1'b1, 1'b1, 16'hface, 16'h0204);
    check("b_fl_instr", 0, 32'(bus_b.instr_out), 32'h0800);
    check("b_fl_valid", 0, 32'(bus_b.valid_out), 32'd0);
    check("b_fl_pc", 0, 32'(bus_b.pc_out), 32'h0200);
    check("b_fl_flushing", 0, 32'(bus_b.flushing), 32'd0);
    check("b_fl_cnt", 0, 32'(bus_b.bubble_cnt), 32'd1);
    drive_b(1'b0, 1'b0, 1'b0, 1'b1, 16'hbead, 16'h0208);
    check("b_post_instr", 0, 32'(bus_b.instr_out), 32'hbead);
    check("b_post_valid", 0, 32'(bus_b.valid_out), 32'd1);
    check("b_post_cnt", 0, 32'(bus_b.bubble_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
